divider_66: RTL and testbench

DIVIDER_66 -- requirements
Module: divider_66

---
 rtl/divider_66.sv | 152 +++++++++++++++
 tb/tb_divider_66.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_66.sv
// divider_66 -- sequential restoring divider.
//
// Divides a 2*div_size-bit dividend by a div_size-bit divisor. The result is
// produced one quotient bit per clock, MSB first.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready. A result is consumed on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE, and out_valid is
// high only in DONE. Result fields are held stable until they are consumed.
//
// A divide-by-zero, or a dividend high half >= divisor (quotient overflow),
// goes straight from IDLE to DONE. In that case err=1, quotient is all ones
// and remainder is the low half of the dividend.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  operation request handshake
//   dividend        2*div_size-bit numerator
//   divisor         div_size-bit denominator
//   out_valid/ready result handshake
//   quotient        div_size-bit quotient
//   remainder       div_size-bit remainder
//   err             divide-by-zero / overflow flag
//   dbg_state       current FSM state (0=IDLE, 1=RUN, 2=DONE)
module divider_66 #(
  parameter int div_size = 66
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*div_size-1:0]   dividend,
  input  logic [div_size-1:0]     divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [div_size-1:0]     quotient,
  output logic [div_size-1:0]     remainder,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  localparam int W  = div_size;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_rem;   // partial remainder (always < divisor between steps)
  logic [W-1:0]   r_lo;    // unconsumed dividend bits; quotient bits enter at LSB
  logic [W-1:0]   r_div;
  logic           r_err;

  logic           w_accept;
  logic [W:0]     w_shift;
  logic [W:0]     w_sub_a;
  logic [W:0]     w_sub_b;
  logic [W+1:0]   w_sub_full;
  logic           w_ge;
  logic           w_last;
  logic           w_unused_sub_msb;

  // Partial remainder for this step: shift in the next dividend bit.
  assign w_shift = {r_rem, r_lo[W-1]};

  // One subtractor, shared between the overflow check in IDLE and the
  // restoring step in RUN. A clear borrow means a >= b. With divisor==0 the
  // IDLE compare is always >=, so it covers divide-by-zero as well.
  assign w_sub_a    = (r_state == IDLE) ? {1'b0, dividend[2*W-1:W]} : w_shift;
  assign w_sub_b    = {1'b0, (r_state == IDLE) ? divisor : r_div};
  assign w_sub_full = {1'b0, w_sub_a} - {1'b0, w_sub_b};
  assign w_ge       = ~w_sub_full[W+1];
  // When a >= b the difference is below the divisor, so bit W is always zero.
  assign w_unused_sub_msb = w_sub_full[W];

  assign w_last = (r_cnt == CW'(W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (w_accept) w_next = w_ge ? DONE : RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_lo  <= '0;
      r_div <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div <= divisor;
            r_cnt <= '0;
            if (w_ge) begin
              r_err <= 1'b1;
              r_lo  <= '1;
              r_rem <= dividend[W-1:0];
            end else begin
              r_err <= 1'b0;
              r_rem <= dividend[2*W-1:W];
              r_lo  <= dividend[W-1:0];
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_ge ? w_sub_full[W-1:0] : w_shift[W-1:0];
          r_lo  <= {r_lo[W-2:0], w_ge};
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_lo;
  assign remainder = r_rem;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_divider_66.sv
// tb_divider_66 -- directed-vector bench for divider_66.
module tb_divider_66;

  localparam int W = 66;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             err;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ones;

  divider_66 #(.div_size(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Driver tasks. Inputs change on the falling edge; outputs are sampled
  // 1 time unit after the rising edge.
  task automatic send(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts the rising edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take_result;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL reset_remainder got=%0d want=0", remainder); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
  endtask

  task automatic test_basic;
    int n;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b want=1", in_ready); end
    send(132'd100, 66'd7);
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL basic_run_state got=%0d want=1", dbg_state); end
    wait_valid(n);
    total++; if (n != 66) begin bad++; $display("FAIL basic_latency got=%0d want=66", n); end
    total++; if (quotient !== 66'd14) begin bad++; $display("FAIL basic_q got=%0d want=14", quotient); end
    total++; if (remainder !== 66'd2) begin bad++; $display("FAIL basic_r got=%0d want=2", remainder); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b want=0", err); end
    take_result();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b want=0", out_valid); end
  endtask

  task automatic test_vectors;
    logic [2*W-1:0] v_dd [5];
    logic [W-1:0]   v_dv [5];
    logic [W-1:0]   v_q  [5];
    logic [W-1:0]   v_r  [5];
    int n;
    // (2^66-1)^2 / (2^66-1)
    v_dd[0] = {{W{1'b0}}, ones} * {{W{1'b0}}, ones}; v_dv[0] = ones; v_q[0] = ones; v_r[0] = '0;
    v_dd[1] = 132'd1000000; v_dv[1] = 66'd3; v_q[1] = 66'd333333; v_r[1] = 66'd1;
    v_dd[2] = (132'd1 << 70) + 132'd5; v_dv[2] = 66'd1024; v_q[2] = 66'd1 << 60; v_r[2] = 66'd5;
    v_dd[3] = 132'd12345; v_dv[3] = 66'd1; v_q[3] = 66'd12345; v_r[3] = 66'd0;
    // High half = divisor-1: largest non-overflowing case for divisor 5.
    v_dd[4] = 132'd4 << 66; v_dv[4] = 66'd5; v_q[4] = 66'd59029581035870565171; v_r[4] = 66'd1;
    for (int i = 0; i < 5; i++) begin
      send(v_dd[i], v_dv[i]);
      wait_valid(n);
      total++; if (n != 66) begin bad++; $display("FAIL vec%0d_latency got=%0d want=66", i, n); end
      total++; if (quotient !== v_q[i]) begin bad++; $display("FAIL vec%0d_q got=%0d want=%0d", i, quotient, v_q[i]); end
      total++; if (remainder !== v_r[i]) begin bad++; $display("FAIL vec%0d_r got=%0d want=%0d", i, remainder, v_r[i]); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL vec%0d_err got=%0b want=0", i, err); end
      take_result();
    end
  endtask

  // An error result is already present before edge T+1 arrives.
  task automatic test_div_zero;
    int n;
    send(132'h123, 66'd0);
    wait_valid(n);
    total++; if (n != 0) begin bad++; $display("FAIL divzero_latency got=%0d want=0", n); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL divzero_err got=%0b want=1", err); end
    total++; if (quotient !== ones) begin bad++; $display("FAIL divzero_q got=%0h want=%0h", quotient, ones); end
    total++; if (remainder !== 66'h123) begin bad++; $display("FAIL divzero_r got=%0h want=123", remainder); end
    take_result();
  endtask

  task automatic test_overflow;
    int n;
    send(132'd5 << 66, 66'd5);
    wait_valid(n);
    total++; if (n != 0) begin bad++; $display("FAIL ovf_latency got=%0d want=0", n); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b want=1", err); end
    total++; if (quotient !== ones) begin bad++; $display("FAIL ovf_q got=%0h want=%0h", quotient, ones); end
    total++; if (remainder !== 66'd0) begin bad++; $display("FAIL ovf_r got=%0d want=0", remainder); end
    take_result();
  endtask

  task automatic test_backpressure;
    int n;
    send(132'd100, 66'd7);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      dividend = 132'd50;
      divisor  = 66'd3;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%0b want=1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%0b want=0", i, in_ready); end
      total++; if (quotient !== 66'd14 || remainder !== 66'd2 || err !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=q%0d r%0d e%0b want=q14 r2 e0", i, quotient, remainder, err);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_result();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%0b want=1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL bp_no_accept got=%0d want=0", dbg_state); end
  endtask

  task automatic test_reset_abort;
    int n;
    logic seen;
    send(132'd100, 66'd7);
    repeat (30) @(posedge clk);
    #1;
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL abort_running got=%0d want=1", dbg_state); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL abort_clear got=v%0b q%0d r%0d e%0b want=0", out_valid, quotient, remainder, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%0b want=1", in_ready); end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_output got=%0b want=0", seen); end
    send(132'd100, 66'd7);
    wait_valid(n);
    total++; if (quotient !== 66'd14 || remainder !== 66'd2 || n != 66) begin
      bad++; $display("FAIL abort_redo got=q%0d r%0d lat%0d want=q14 r2 lat66", quotient, remainder, n);
    end
    take_result();
  endtask

  // out_ready held high throughout: the result still arrives on time and is
  // taken on the edge after it appears.
  task automatic test_early_ready;
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    send(132'd999, 66'd10);
    wait_valid(n);
    total++; if (n != 66) begin bad++; $display("FAIL early_latency got=%0d want=66", n); end
    total++; if (quotient !== 66'd99 || remainder !== 66'd9) begin
      bad++; $display("FAIL early_result got=q%0d r%0d want=q99 r9", quotient, remainder);
    end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL early_consumed got=v%0b rdy%0b want=v0 rdy1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    ones = '1;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    test_early_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
